sync_fifo_ext: RTL and testbench

Parametrised successor to the single-clock FIFO. It adds:
- selectable standard or first-word-fall-through (FWFT) read mode
- programmable almost-full and almost-empty flags
- synchronous flush
- sticky overflow/underflow error flags

It sits between producer and consumer logic in one clock domain. Its external handshake is unchanged from the existing FIFO, so it drops in where that FIFO is used.

---
 rtl/sync_fifo_ext.sv | 109 ++++++++++
 tb/tb_sync_fifo_ext.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with standard/FWFT read modes, programmable almost-full/empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_ext #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 8,
  parameter int FWFT       = 0,
  parameter int AFULL_TH   = DATA_DEPTH - 2,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush_i,
  input  logic                          wr_en_i,
  input  logic [DATA_WIDTH-1:0]         wr_data_i,
  input  logic                          rd_en_i,
  output logic                          rd_data_valid_o,
  output logic [DATA_WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DATA_DEPTH):0]   elem_cnt_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic                          almost_full_o,
  output logic                          almost_empty_o,
  output logic                          overflow_o,
  output logic                          underflow_o
);

  localparam int PTR_W = $clog2(DATA_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  full_q, empty_q, afull_q, aempty_q;
  logic                  ovf_q, udf_q;
  logic                  wr_acc, rd_acc, clear;

  // A write into a full FIFO is admitted only when a read frees a slot this cycle.
  always_comb begin
    clear  = ~rst_n | flush_i;
    rd_acc = rd_en_i & ~empty_q;
    wr_acc = wr_en_i & (~full_q | rd_acc);
    cnt_d  = cnt_q;
    if (wr_acc && !rd_acc)      cnt_d = cnt_q + CNT_W'(1);
    else if (rd_acc && !wr_acc) cnt_d = cnt_q - CNT_W'(1);
  end

  // NOTE: the storage array is deliberately not reset; validity is tracked by the
  // pointers and count, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (!clear && wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == CNT_W'(DATA_DEPTH));
      empty_q  <= (cnt_d == '0);
      afull_q  <= (cnt_d >= CNT_W'(AFULL_TH));
      aempty_q <= (cnt_d <= CNT_W'(AEMPTY_TH));
      ovf_q    <= ovf_q | (wr_en_i & ~wr_acc);
      udf_q    <= udf_q | (rd_en_i & ~rd_acc);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head is presented combinationally; forced to zero while empty so reset/flush read as 0.
      assign rd_data_valid_o = ~empty_q;
      assign rd_data_o       = empty_q ? '0 : mem_q[rd_ptr_q];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      always_ff @(posedge clk) begin
        if (clear) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
        end
      end

      assign rd_data_valid_o = rd_valid_q;
      assign rd_data_o       = rd_data_q;
    end
  endgenerate

  assign elem_cnt_o     = cnt_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Drives a standard-mode and an FWFT-mode sync_fifo_ext with identical stimulus and
// compares both against a queue-based reference model every cycle.
module tb_sync_fifo_ext;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AF_TH = 6;
  localparam int AE_TH = 2;

  logic          clk = 1'b0;
  logic          rst_n, flush_i, wr_en_i, rd_en_i;
  logic [DW-1:0] wr_data_i;

  logic          s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic [DW-1:0] s_data;
  logic [3:0]    s_cnt;
  logic          f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [DW-1:0] f_data;
  logic [3:0]    f_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  bit            m_ovf, m_udf, m_sv;
  logic [DW-1:0] m_sd;

  always #5 clk = ~clk;

  sync_fifo_ext #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .FWFT(0),
                  .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH)) u_std (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .wr_en_i(wr_en_i),
    .wr_data_i(wr_data_i), .rd_en_i(rd_en_i), .rd_data_valid_o(s_valid),
    .rd_data_o(s_data), .elem_cnt_o(s_cnt), .full_o(s_full), .empty_o(s_empty),
    .almost_full_o(s_af), .almost_empty_o(s_ae), .overflow_o(s_ovf),
    .underflow_o(s_udf)
  );

  sync_fifo_ext #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .FWFT(1),
                  .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .wr_en_i(wr_en_i),
    .wr_data_i(wr_data_i), .rd_en_i(rd_en_i), .rd_data_valid_o(f_valid),
    .rd_data_o(f_data), .elem_cnt_o(f_cnt), .full_o(f_full), .empty_o(f_empty),
    .almost_full_o(f_af), .almost_empty_o(f_ae), .overflow_o(f_ovf),
    .underflow_o(f_udf)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check("std_cnt",    DW'(s_cnt), DW'(n));
    check("std_full",   DW'(s_full),  DW'(n == DEPTH));
    check("std_empty",  DW'(s_empty), DW'(n == 0));
    check("std_afull",  DW'(s_af),    DW'(n >= AF_TH));
    check("std_aempty", DW'(s_ae),    DW'(n <= AE_TH));
    check("std_ovf",    DW'(s_ovf),   DW'(m_ovf));
    check("std_udf",    DW'(s_udf),   DW'(m_udf));
    check("std_valid",  DW'(s_valid), DW'(m_sv));
    check("std_data",   s_data,       m_sd);
    check("fwft_cnt",   DW'(f_cnt), DW'(n));
    check("fwft_full",  DW'(f_full),  DW'(n == DEPTH));
    check("fwft_empty", DW'(f_empty), DW'(n == 0));
    check("fwft_afull", DW'(f_af),    DW'(n >= AF_TH));
    check("fwft_aempty",DW'(f_ae),    DW'(n <= AE_TH));
    check("fwft_ovf",   DW'(f_ovf),   DW'(m_ovf));
    check("fwft_udf",   DW'(f_udf),   DW'(m_udf));
    check("fwft_valid", DW'(f_valid), DW'(n != 0));
    check("fwft_data",  f_data,       (n != 0) ? q[0] : '0);
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input bit r, input bit f, input bit w, input logic [DW-1:0] d, input bit rd);
    bit ra, wa;
    rst_n = r; flush_i = f; wr_en_i = w; wr_data_i = d; rd_en_i = rd;
    if (!r || f) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_sv = 0; m_sd = '0;
    end else begin
      ra = rd && (q.size() > 0);
      wa = w && ((q.size() < DEPTH) || ra);
      m_sv = ra;
      if (ra) m_sd = q.pop_front();
      if (wa) q.push_back(d);
      if (w && !wa)  m_ovf = 1;
      if (rd && !ra) m_udf = 1;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic push(input logic [DW-1:0] d); step(1, 0, 1, d, 0); endtask
  task automatic pop();                        step(1, 0, 0, '0, 1); endtask
  task automatic idle();                       step(1, 0, 0, '0, 0); endtask
  task automatic flush();                      step(1, 1, 0, '0, 0); endtask

  initial begin
    // 1: reset, reads on empty, flush clears underflow
    step(0, 0, 0, '0, 0);
    step(0, 1, 1, 32'hDEAD, 1);
    for (int i = 0; i < 4; i++) pop();
    check("p1_udf_set", DW'(s_udf), DW'(1));
    step(1, 1, 1, 32'h77, 1);
    check("p1_udf_clr", DW'(s_udf), DW'(0));

    // 2: overfill then pop three
    for (int i = 5; i <= 14; i++) push(DW'(i));
    check("p2_ovf", DW'(s_ovf), DW'(1));
    for (int i = 0; i < 3; i++) pop();
    check("p2_cnt", DW'(s_cnt), DW'(5));

    // 3: refill to full, simultaneous read+write, drain
    for (int i = 0; i < 3; i++) push(DW'(100 + i));
    step(1, 0, 1, DW'(23), 1);
    check("p3_full", DW'(s_full), DW'(1));
    for (int i = 0; i < 8; i++) pop();
    check("p3_last", s_data, DW'(23));
    idle();

    // 4: write+read while empty
    flush();
    step(1, 0, 1, DW'(45), 1);
    check("p4_cnt", DW'(s_cnt), DW'(1));

    // 5: threshold sweep
    flush();
    for (int i = 0; i < DEPTH; i++) push($urandom);
    for (int i = 0; i < DEPTH; i++) pop();

    // 6: FWFT head presentation and mid-stream reset
    flush();
    push(32'hA5);
    idle();
    check("p6_head", f_data, 32'hA5);
    push(32'hB6);
    pop();
    check("p6_next", f_data, 32'hB6);
    push(32'hC7);
    step(0, 0, 1, 32'hD8, 1);
    check("p6_rst_data", f_data, '0);

    // Randomized traffic with wrap-around, occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 79) == 0),
           ($urandom_range(0, 99) < 55), $urandom, ($urandom_range(0, 99) < 45));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
